sr_flag_bank: RTL and testbench
===============================

Name: sr_flag_bank

Overview:
- Parametrised, clocked successor to the single SR latch: a bank of N synchronous SR flag cells sharing one clock.
- Adds a selectable S&R conflict-resolution mode, optional per-channel auto-clear timeout, rising-edge pulses and a saturating conflict counter.
- Holds the controller's status flags (door open, cooking, alarm, ...) and feeds the control FSM and display logic.

Parameters:
N, 4, number of independent flag channels (1..32)
MODE, 0, S&R conflict policy: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle
TIMEOUT, 0, auto-clear after TIMEOUT cycles high; 0 disables auto-clear
CNT_W, 8, width of conflict_cnt

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  global update enable; 0 freezes all channel state
S  in  N  per-channel set request, sampled at clk edge
R  in  N  per-channel reset request, sampled at clk edge
clr_cnt  in  1  synchronous clear of conflict_cnt
Q  out  N  flag state, registered
Q_bar  out  N  always ~Q (combinational from Q)
rise  out  N  1-cycle pulse, high in the first cycle Q[i] is 1 after a 0->1 transition
conflict_cnt  out  CNT_W  saturating count of enabled cycles with any S[i]&R[i]

Behaviour:
- Reset (rst_n=0 at edge): Q=0, Q_bar=all ones, rise=0, conflict_cnt=0, all timers 0. Reset overrides en, S, R, clr_cnt.
- en=0: Q, timers and conflict_cnt hold; rise=0 the next cycle. clr_cnt still acts.
- en=1, next state per channel, in priority order:
  - S&R: MODE0 -> 0; MODE1 -> 1 and timer restart; MODE2 -> hold; MODE3 -> ~Q (timer restarts if result is 1).
  - S only: Q=1, timer restarts at 0 (retrigger even if already 1).
  - R only: Q=0, timer=0.
  - Neither, Q=1, TIMEOUT>0, timer==TIMEOUT-1: Q=0 (expiry), timer=0.
  - Neither otherwise: hold Q; timer+1 while Q=1 and TIMEOUT>0.
- Latency: one cycle from sampled S/R to Q; no combinational path from S/R to Q.
- Timeout: single S pulse sampled at edge k gives Q=1 after edge k and Q=0 after edge k+TIMEOUT, i.e. exactly TIMEOUT cycles high. Timer width = clog2(TIMEOUT+1), minimum 1. S on the expiry cycle wins (retrigger). R on the expiry cycle gives 0.
- rise[i] is registered as (next_Q[i] & ~Q[i]) in the same edge that updates Q. Toggle mode produces rise on every 0->1 flip.
- conflict_cnt:
  - +1 on each edge with en=1 and |(S&R) != 0, regardless of MODE or the number of conflicting channels.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 gives 0 and beats the increment.
- Channels are fully independent apart from the shared en and conflict_cnt.
- Reset mid-timeout clears timers; no expiry or rise pulse follows reset.

Test Plan:
- Reset/basic (N=4, MODE0, TIMEOUT=0): rst_n=0 two cycles -> Q=4'b0000, Q_bar=4'b1111, conflict_cnt=0. S=4'b0101 one cycle -> Q=0101, rise=0101 for one cycle only. R=4'b0001 -> Q=0100.
- Conflict modes: S=R=4'b0001 one cycle, Q0 initially 1 -> MODE0 Q0=0; MODE1 Q0=1; MODE2 Q0=1; MODE3 Q0=0. Next conflict in MODE3 -> Q0=1 with rise0=1. conflict_cnt=1 then 2.
- Timeout (TIMEOUT=5): S[2] pulse at edge k -> Q[2]=1 for exactly 5 cycles, 0 after edge k+5. S[2] re-pulse at k+3 -> Q[2] falls after k+8. S[2] on the expiry cycle -> stays 1, timer restarts.
- Enable freeze: Q=0010 with timer=2, en=0 for 10 cycles with S/R toggling -> Q, timer and conflict_cnt unchanged, rise=0. en=1 -> expiry resumes with 3 cycles remaining (TIMEOUT=5).
- Counter saturation (CNT_W=3): 9 enabled conflict cycles -> conflict_cnt stops at 7. clr_cnt together with a conflict -> 0. Next conflict -> 1.
- Reset mid-operation: rst_n=0 while Q=1111 and timers mid-count -> next cycle Q=0000, rise=0000. Releasing reset with S=R=0 -> no spurious rise or expiry.

Source files
------------

// File: rtl/sr_flag_bank.sv
// Bank of N clocked SR flag cells with a configurable S&R policy, optional
// auto-clear timeout, rising-edge pulses and a saturating conflict counter.
module sr_flag_bank #(
  parameter int N       = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     R,
  input  logic             clr_cnt,
  output logic [N-1:0]     Q,
  output logic [N-1:0]     Q_bar,
  output logic [N-1:0]     rise,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    POL_RESET  = 2'd0,
    POL_SET    = 2'd1,
    POL_HOLD   = 2'd2,
    POL_TOGGLE = 2'd3
  } policy_e;

  localparam policy_e POLICY = policy_e'(2'(MODE));
  localparam bit      TO_EN  = (TIMEOUT > 0);
  localparam int      TW     = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

  logic [N-1:0]          q_q, q_d;
  logic [N-1:0]          rise_q, rise_d;
  logic [N-1:0][TW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    q_d     = q_q;
    timer_d = timer_q;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (S[i] && R[i]) begin
          case (POLICY)
            POL_RESET: begin
              q_d[i]     = 1'b0;
              timer_d[i] = '0;
            end
            POL_SET: begin
              q_d[i]     = 1'b1;
              timer_d[i] = '0;
            end
            POL_HOLD: begin
              q_d[i]     = q_q[i];
              timer_d[i] = timer_q[i];
            end
            default: begin
              q_d[i]     = ~q_q[i];
              timer_d[i] = '0;
            end
          endcase
        end else if (S[i]) begin
          q_d[i]     = 1'b1;
          timer_d[i] = '0;
        end else if (R[i]) begin
          q_d[i]     = 1'b0;
          timer_d[i] = '0;
        end else if (TO_EN && q_q[i] && (timer_q[i] == T_LAST)) begin
          q_d[i]     = 1'b0;
          timer_d[i] = '0;
        end else if (TO_EN && q_q[i]) begin
          timer_d[i] = timer_q[i] + TW'(1);
        end
      end
    end
    // q_d equals q_q whenever en is low, so rise drops automatically on freeze
    rise_d = q_d & ~q_q;

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (en && (|(S & R)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= '0;
      rise_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      rise_q  <= rise_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q            = q_q;
  assign Q_bar        = ~q_q;
  assign rise         = rise_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: four conflict-policy instances plus one
// instance with TIMEOUT=5 and a 3-bit conflict counter, all sharing stimulus.
module tb_sr_flag_bank;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_cnt;
  logic [3:0] S, R;

  logic [3:0] q0, qb0, r0, q1, qb1, r1, q2, qb2, r2, q3, qb3, r3, qt, qbt, rt;
  logic [7:0] c0, c1, c2, c3;
  logic [2:0] ct;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sr_flag_bank #(.N(4), .MODE(0), .TIMEOUT(0), .CNT_W(8)) u_m0 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_cnt(clr_cnt),
    .Q(q0), .Q_bar(qb0), .rise(r0), .conflict_cnt(c0));
  sr_flag_bank #(.N(4), .MODE(1), .TIMEOUT(0), .CNT_W(8)) u_m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_cnt(clr_cnt),
    .Q(q1), .Q_bar(qb1), .rise(r1), .conflict_cnt(c1));
  sr_flag_bank #(.N(4), .MODE(2), .TIMEOUT(0), .CNT_W(8)) u_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_cnt(clr_cnt),
    .Q(q2), .Q_bar(qb2), .rise(r2), .conflict_cnt(c2));
  sr_flag_bank #(.N(4), .MODE(3), .TIMEOUT(0), .CNT_W(8)) u_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_cnt(clr_cnt),
    .Q(q3), .Q_bar(qb3), .rise(r3), .conflict_cnt(c3));
  sr_flag_bank #(.N(4), .MODE(0), .TIMEOUT(5), .CNT_W(3)) u_t (
    .clk(clk), .rst_n(rst_n), .en(en), .S(S), .R(R), .clr_cnt(clr_cnt),
    .Q(qt), .Q_bar(qbt), .rise(rt), .conflict_cnt(ct));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b1; S = '0; R = '0; clr_cnt = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; S = 4'b1111; R = 4'b0000; clr_cnt = 1'b0;
    tick(2);
    tests++; if (q0 !== 4'b0000) begin fails++; $display("FAIL reset_q got %b want 0000", q0); end
    tests++; if (qb0 !== 4'b1111) begin fails++; $display("FAIL reset_qbar got %b want 1111", qb0); end
    tests++; if (c0 !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", c0); end
    tests++; if (qt !== 4'b0000 || rt !== 4'b0000) begin fails++; $display("FAIL reset_t got q=%b rise=%b want 0000/0000", qt, rt); end
    S = '0; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    S = 4'b0101; tick(1);
    tests++; if (q0 !== 4'b0101) begin fails++; $display("FAIL set_q got %b want 0101", q0); end
    tests++; if (qb0 !== 4'b1010) begin fails++; $display("FAIL set_qbar got %b want 1010", qb0); end
    tests++; if (r0 !== 4'b0101) begin fails++; $display("FAIL set_rise got %b want 0101", r0); end
    S = 4'b0000; tick(1);
    tests++; if (q0 !== 4'b0101 || r0 !== 4'b0000) begin fails++; $display("FAIL hold got q=%b rise=%b want 0101/0000", q0, r0); end
    S = 4'b0101; tick(1);
    tests++; if (r0 !== 4'b0000) begin fails++; $display("FAIL reset_no_rise got %b want 0000", r0); end
    S = 4'b0000; R = 4'b0001; tick(1);
    tests++; if (q0 !== 4'b0100) begin fails++; $display("FAIL clear_q got %b want 0100", q0); end
    R = 4'b0000;
  endtask

  task automatic test_conflict();
    apply_reset();
    S = 4'b0001; tick(1);
    tests++; if ({q0[0], q1[0], q2[0], q3[0]} !== 4'b1111) begin fails++; $display("FAIL conf_pre got %b want 1111", {q0[0], q1[0], q2[0], q3[0]}); end
    S = 4'b0001; R = 4'b0001; tick(1);
    tests++; if ({q0[0], q1[0], q2[0], q3[0]} !== 4'b0110) begin fails++; $display("FAIL conf_modes got %b want 0110", {q0[0], q1[0], q2[0], q3[0]}); end
    tests++; if (c0 !== 8'd1 || c3 !== 8'd1) begin fails++; $display("FAIL conf_cnt1 got %0d/%0d want 1/1", c0, c3); end
    tests++; if ({r1[0], r2[0], r3[0]} !== 3'b000) begin fails++; $display("FAIL conf_rise0 got %b want 000", {r1[0], r2[0], r3[0]}); end
    tick(1);
    tests++; if (q3 !== 4'b0001 || r3 !== 4'b0001) begin fails++; $display("FAIL toggle_rise got q=%b rise=%b want 0001/0001", q3, r3); end
    tests++; if (c3 !== 8'd2 || c1 !== 8'd2) begin fails++; $display("FAIL conf_cnt2 got %0d/%0d want 2/2", c3, c1); end
    tests++; if ({q0[0], q1[0], q2[0]} !== 3'b011) begin fails++; $display("FAIL conf_modes2 got %b want 011", {q0[0], q1[0], q2[0]}); end
    S = '0; R = '0; tick(1);
    tests++; if (r3 !== 4'b0000 || q3 !== 4'b0001) begin fails++; $display("FAIL toggle_after got q=%b rise=%b want 0001/0000", q3, r3); end
  endtask

  task automatic test_timeout();
    apply_reset();
    S = 4'b0100; tick(1); S = '0;
    tests++; if (qt !== 4'b0100 || rt !== 4'b0100) begin fails++; $display("FAIL to_set got q=%b rise=%b want 0100/0100", qt, rt); end
    for (int j = 1; j <= 4; j++) begin
      tick(1);
      tests++; if (qt !== 4'b0100) begin fails++; $display("FAIL to_high k+%0d got %b want 0100", j, qt); end
    end
    tick(1);
    tests++; if (qt !== 4'b0000 || rt !== 4'b0000) begin fails++; $display("FAIL to_expire got q=%b rise=%b want 0000/0000", qt, rt); end

    S = 4'b0100; tick(1); S = '0; tick(2);
    S = 4'b0100; tick(1); S = '0;
    tick(4);
    tests++; if (qt !== 4'b0100) begin fails++; $display("FAIL retrig_k7 got %b want 0100", qt); end
    tick(1);
    tests++; if (qt !== 4'b0000) begin fails++; $display("FAIL retrig_k8 got %b want 0000", qt); end

    S = 4'b0100; tick(1); S = '0; tick(4);
    S = 4'b0100; tick(1); S = '0;
    tests++; if (qt !== 4'b0100 || rt !== 4'b0000) begin fails++; $display("FAIL exp_set got q=%b rise=%b want 0100/0000", qt, rt); end
    tick(4);
    tests++; if (qt !== 4'b0100) begin fails++; $display("FAIL exp_set_hold got %b want 0100", qt); end
    tick(1);
    tests++; if (qt !== 4'b0000) begin fails++; $display("FAIL exp_set_fall got %b want 0000", qt); end

    S = 4'b0100; tick(1); S = '0; tick(3);
    R = 4'b0100; tick(1); R = '0;
    tests++; if (qt !== 4'b0000) begin fails++; $display("FAIL exp_reset got %b want 0000", qt); end
  endtask

  task automatic test_freeze();
    apply_reset();
    S = 4'b0010; tick(1); S = '0; tick(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      S = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      R = (i % 3 == 0) ? 4'b0011 : 4'b1100;
      tick(1);
      tests++; if (qt !== 4'b0010 || rt !== 4'b0000 || ct !== 3'd0) begin fails++; $display("FAIL freeze cyc%0d got q=%b rise=%b cnt=%0d want 0010/0000/0", i, qt, rt, ct); end
    end
    S = '0; R = '0; en = 1'b1;
    tick(2);
    tests++; if (qt !== 4'b0010) begin fails++; $display("FAIL resume_hold got %b want 0010", qt); end
    tick(1);
    tests++; if (qt !== 4'b0000) begin fails++; $display("FAIL resume_expire got %b want 0000", qt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    S = 4'b0001; R = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      tests++; if (ct !== ((i > 7) ? 3'd7 : 3'(i))) begin fails++; $display("FAIL sat step%0d got %0d want %0d", i, ct, (i > 7) ? 7 : i); end
    end
    tests++; if (c0 !== 8'd9) begin fails++; $display("FAIL wide_cnt got %0d want 9", c0); end
    clr_cnt = 1'b1; tick(1);
    tests++; if (ct !== 3'd0 || c0 !== 8'd0) begin fails++; $display("FAIL clr_beats_inc got %0d/%0d want 0/0", ct, c0); end
    clr_cnt = 1'b0; tick(1);
    tests++; if (ct !== 3'd1) begin fails++; $display("FAIL after_clr got %0d want 1", ct); end
    S = '0; R = '0; en = 1'b0; clr_cnt = 1'b1; tick(1);
    tests++; if (ct !== 3'd0) begin fails++; $display("FAIL clr_frozen got %0d want 0", ct); end
    en = 1'b1; clr_cnt = 1'b0; S = 4'b1100; R = 4'b0011; tick(1);
    tests++; if (ct !== 3'd0) begin fails++; $display("FAIL no_overlap got %0d want 0", ct); end
    S = '0; R = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    S = 4'b1111; tick(1); S = '0; tick(2);
    tests++; if (qt !== 4'b1111) begin fails++; $display("FAIL mid_pre got %b want 1111", qt); end
    rst_n = 1'b0; tick(1);
    tests++; if (qt !== 4'b0000 || rt !== 4'b0000) begin fails++; $display("FAIL mid_reset got q=%b rise=%b want 0000/0000", qt, rt); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      tests++; if (qt !== 4'b0000 || rt !== 4'b0000) begin fails++; $display("FAIL post_reset cyc%0d got q=%b rise=%b want 0000/0000", i, qt, rt); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; S = '0; R = '0; clr_cnt = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_timeout();
    test_freeze();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
